// File: rtl/csi2_lane_packetizer_if.sv
// Packet request, payload stream and per-lane LP/HS outputs of the two-lane CSI-2 packetizer.
// slave is the packetizer side; master is the side that issues requests and consumes the lanes.
interface csi2_lane_packetizer_if;
  logic        pkt_req;
  logic [7:0]  pkt_di;
  logic [15:0] pkt_wc;
  logic        pkt_ack;
  logic        pkt_err;
  logic [15:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic        underrun;
  logic [1:0]  lp_p;
  logic [1:0]  lp_n;
  logic        hs_en;
  logic [7:0]  hs_byte0;
  logic [7:0]  hs_byte1;
  logic        busy;

  modport slave (
    input  pkt_req, pkt_di, pkt_wc, pl_data, pl_valid,
    output pkt_ack, pkt_err, pl_ready, underrun, lp_p, lp_n, hs_en, hs_byte0, hs_byte1, busy
  );

  modport master (
    output pkt_req, pkt_di, pkt_wc, pl_data, pl_valid,
    input  pkt_ack, pkt_err, pl_ready, underrun, lp_p, lp_n, hs_en, hs_byte0, hs_byte1, busy
  );
endinterface

// File: rtl/csi2_lane_packetizer.sv
// Two-lane CSI-2 TX packetizer: LP entry, HS zero/sync, header+ECC, payload, CRC16, trail, exit.
// All outputs registered; pkt_ack coincides with the first LP01 cycle. Payload never stalls (underrun fills zeros).
module csi2_lane_packetizer #(
  parameter int T_LPX      = 2,
  parameter int T_HS_PREP  = 2,
  parameter int T_HS_ZERO  = 4,
  parameter int T_HS_TRAIL = 2,
  parameter int T_HS_EXIT  = 3
) (
  input logic                   sys_clk,
  input logic                   reset,
  csi2_lane_packetizer_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_LP01, S_LP00, S_HS_ZERO, S_SYNC, S_HDR1, S_HDR2,
    S_PAYLOAD, S_CRC, S_TRAIL, S_EXIT
  } state_t;

  state_t      r_state;
  logic [14:0] r_cnt;
  logic [7:0]  r_di;
  logic [15:0] r_wc;
  logic [15:0] r_crc;
  logic        r_pkt_ack, r_pkt_err, r_pl_ready, r_underrun, r_hs_en, r_busy;
  logic [1:0]  r_lp_p, r_lp_n;
  logic [7:0]  r_hs_byte0, r_hs_byte1;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = c;
    for (int i = 0; i < 8; i++)
      x = (x[0] ^ b[i]) ? ((x >> 1) ^ 16'h8408) : (x >> 1);
    return x;
  endfunction

  function automatic logic [7:0] ecc_calc(input logic [23:0] h);
    return {2'b00, ^(h & 24'hEFFC00), ^(h & 24'hDF03F0), ^(h & 24'hB8E38E),
            ^(h & 24'h749A6D), ^(h & 24'hF2555B), ^(h & 24'hF12CB7)};
  endfunction

  logic        w_req_long, w_is_long;
  logic [14:0] w_nbeats;
  logic [15:0] w_beat, w_crc_next;
  logic [7:0]  w_ecc;

  assign w_req_long = bus.pkt_di[5:0] > 6'h0F;
  assign w_is_long  = r_di[5:0] > 6'h0F;
  assign w_nbeats   = r_wc[15:1];
  assign w_beat     = bus.pl_valid ? bus.pl_data : 16'h0000;
  assign w_crc_next = crc_byte(crc_byte(r_crc, w_beat[7:0]), w_beat[15:8]);
  assign w_ecc      = ecc_calc({r_wc, r_di});

  // pl_data is sampled on the edge that ends each pl_ready cycle; its bytes are on the lanes the next cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_di       <= '0;
      r_wc       <= '0;
      r_crc      <= 16'hFFFF;
      r_pkt_ack  <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_pl_ready <= 1'b0;
      r_underrun <= 1'b0;
      r_hs_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_lp_p     <= 2'b11;
      r_lp_n     <= 2'b11;
      r_hs_byte0 <= 8'h00;
      r_hs_byte1 <= 8'h00;
    end else begin
      r_pkt_ack  <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_pl_ready <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.pkt_req) begin
          if (w_req_long && bus.pkt_wc[0]) begin
            r_pkt_err <= 1'b1;
          end else begin
            r_pkt_ack <= 1'b1;
            r_di      <= bus.pkt_di;
            r_wc      <= bus.pkt_wc;
            r_crc     <= 16'hFFFF;
            r_state   <= S_LP01;
            r_cnt     <= 15'(T_LPX - 1);
            r_lp_p    <= 2'b00;
            r_lp_n    <= 2'b11;
            r_busy    <= 1'b1;
          end
        end
        S_LP01: if (r_cnt != '0) r_cnt <= r_cnt - 15'd1;
        else begin
          r_state <= S_LP00;
          r_cnt   <= 15'(T_HS_PREP - 1);
          r_lp_n  <= 2'b00;
        end
        S_LP00: if (r_cnt != '0) r_cnt <= r_cnt - 15'd1;
        else begin
          r_state    <= S_HS_ZERO;
          r_cnt      <= 15'(T_HS_ZERO - 1);
          r_hs_en    <= 1'b1;
          r_hs_byte0 <= 8'h00;
          r_hs_byte1 <= 8'h00;
        end
        S_HS_ZERO: if (r_cnt != '0) r_cnt <= r_cnt - 15'd1;
        else begin
          r_state    <= S_SYNC;
          r_hs_byte0 <= 8'hB8;
          r_hs_byte1 <= 8'hB8;
        end
        S_SYNC: begin
          r_state    <= S_HDR1;
          r_hs_byte0 <= r_di;
          r_hs_byte1 <= r_wc[7:0];
        end
        S_HDR1: begin
          r_state    <= S_HDR2;
          r_hs_byte0 <= r_wc[15:8];
          r_hs_byte1 <= w_ecc;
          r_pl_ready <= w_is_long && (w_nbeats != '0);
        end
        S_HDR2: if (!w_is_long) begin
          r_state    <= S_TRAIL;
          r_cnt      <= 15'(T_HS_TRAIL - 1);
          r_hs_byte0 <= {8{~r_hs_byte0[7]}};
          r_hs_byte1 <= {8{~r_hs_byte1[7]}};
        end else if (w_nbeats == '0) begin
          r_state    <= S_CRC;
          r_hs_byte0 <= r_crc[7:0];
          r_hs_byte1 <= r_crc[15:8];
        end else begin
          r_state    <= S_PAYLOAD;
          r_cnt      <= w_nbeats - 15'd1;
          r_hs_byte0 <= w_beat[7:0];
          r_hs_byte1 <= w_beat[15:8];
          r_crc      <= w_crc_next;
          r_underrun <= ~bus.pl_valid;
          r_pl_ready <= w_nbeats != 15'd1;
        end
        S_PAYLOAD: if (r_cnt != '0) begin
          r_cnt      <= r_cnt - 15'd1;
          r_hs_byte0 <= w_beat[7:0];
          r_hs_byte1 <= w_beat[15:8];
          r_crc      <= w_crc_next;
          r_underrun <= ~bus.pl_valid;
          r_pl_ready <= r_cnt != 15'd1;
        end else begin
          r_state    <= S_CRC;
          r_hs_byte0 <= r_crc[7:0];
          r_hs_byte1 <= r_crc[15:8];
        end
        S_CRC: begin
          r_state    <= S_TRAIL;
          r_cnt      <= 15'(T_HS_TRAIL - 1);
          r_hs_byte0 <= {8{~r_hs_byte0[7]}};
          r_hs_byte1 <= {8{~r_hs_byte1[7]}};
        end
        S_TRAIL: if (r_cnt != '0) r_cnt <= r_cnt - 15'd1;
        else begin
          r_state    <= S_EXIT;
          r_cnt      <= 15'(T_HS_EXIT - 1);
          r_hs_en    <= 1'b0;
          r_hs_byte0 <= 8'h00;
          r_hs_byte1 <= 8'h00;
          r_lp_p     <= 2'b11;
          r_lp_n     <= 2'b11;
        end
        S_EXIT: if (r_cnt != '0) r_cnt <= r_cnt - 15'd1;
        else begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pkt_ack  = r_pkt_ack;
  assign bus.pkt_err  = r_pkt_err;
  assign bus.pl_ready = r_pl_ready;
  assign bus.underrun = r_underrun;
  assign bus.lp_p     = r_lp_p;
  assign bus.lp_n     = r_lp_n;
  assign bus.hs_en    = r_hs_en;
  assign bus.hs_byte0 = r_hs_byte0;
  assign bus.hs_byte1 = r_hs_byte1;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_csi2_lane_packetizer.sv
// Scoreboard bench: a per-cycle expected lane trace is queued for each request and compared at negedge.
module tb_csi2_lane_packetizer;
  localparam int T_LPX = 2, T_HS_PREP = 2, T_HS_ZERO = 4, T_HS_TRAIL = 2, T_HS_EXIT = 3;

  logic sys_clk = 1'b0;
  logic reset;
  always #5 sys_clk = ~sys_clk;

  csi2_lane_packetizer_if bus();
  csi2_lane_packetizer dut (.sys_clk(sys_clk), .reset(reset), .bus(bus));

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [25:0] sb_q[$];
  logic [15:0] beats[$];
  bit          beat_vld[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {ack, err, busy, lp_p, lp_n, hs_en, pl_ready, underrun, hs_byte1, hs_byte0}
  function automatic logic [25:0] pack(input logic ack, input logic err, input logic busy,
                                       input logic [1:0] lp_p, input logic [1:0] lp_n,
                                       input logic hs, input logic rdy, input logic und,
                                       input logic [7:0] b1, input logic [7:0] b0);
    return {ack, err, busy, lp_p, lp_n, hs, rdy, und, b1, b0};
  endfunction

  function automatic logic [25:0] obs();
    return pack(bus.pkt_ack, bus.pkt_err, bus.busy, bus.lp_p, bus.lp_n, bus.hs_en,
                bus.pl_ready, bus.underrun, bus.hs_byte1, bus.hs_byte0);
  endfunction

  function automatic logic [7:0] ecc_ref(input logic [23:0] h);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < 24; i++) begin
      if (h[i]) begin
        if (i inside {0, 1, 2, 4, 5, 7, 10, 11, 13, 16, [20:23]}) p[0] = ~p[0];
        if (i inside {0, 1, 3, 4, 6, 8, 10, 12, 14, 17, [20:23]}) p[1] = ~p[1];
        if (i inside {0, 2, 3, 5, 6, 9, 11, 12, 15, 18, [20:22]}) p[2] = ~p[2];
        if (i inside {1, 2, 3, 7, 8, 9, 13, 14, 15, 19, 20, 21, 23}) p[3] = ~p[3];
        if (i inside {[4:9], [16:20], 22, 23}) p[4] = ~p[4];
        if (i inside {[10:19], [21:23]}) p[5] = ~p[5];
      end
    end
    return {2'b00, p};
  endfunction

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  task automatic build(input logic [7:0] di, input logic [15:0] wc);
    logic        is_long;
    int          n;
    logic [15:0] d, crc;
    logic [7:0]  l0, l1;
    is_long = di[5:0] > 6'h0F;
    n       = is_long ? int'(wc[15:1]) : 0;
    for (int i = 0; i < T_LPX; i++) sb_q.push_back(pack(i == 0, 0, 1, 2'b00, 2'b11, 0, 0, 0, 8'h00, 8'h00));
    for (int i = 0; i < T_HS_PREP; i++) sb_q.push_back(pack(0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 8'h00, 8'h00));
    for (int i = 0; i < T_HS_ZERO; i++) sb_q.push_back(pack(0, 0, 1, 2'b00, 2'b00, 1, 0, 0, 8'h00, 8'h00));
    sb_q.push_back(pack(0, 0, 1, 2'b00, 2'b00, 1, 0, 0, 8'hB8, 8'hB8));
    sb_q.push_back(pack(0, 0, 1, 2'b00, 2'b00, 1, 0, 0, wc[7:0], di));
    l0 = wc[15:8];
    l1 = ecc_ref({wc, di});
    sb_q.push_back(pack(0, 0, 1, 2'b00, 2'b00, 1, n > 0, 0, l1, l0));
    crc = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      d   = beat_vld[i] ? beats[i] : 16'h0000;
      crc = crc_ref(crc_ref(crc, d[7:0]), d[15:8]);
      sb_q.push_back(pack(0, 0, 1, 2'b00, 2'b00, 1, i < n - 1, !beat_vld[i], d[15:8], d[7:0]));
      l0 = d[7:0];
      l1 = d[15:8];
    end
    if (is_long) begin
      sb_q.push_back(pack(0, 0, 1, 2'b00, 2'b00, 1, 0, 0, crc[15:8], crc[7:0]));
      l0 = crc[7:0];
      l1 = crc[15:8];
    end
    for (int i = 0; i < T_HS_TRAIL; i++)
      sb_q.push_back(pack(0, 0, 1, 2'b00, 2'b00, 1, 0, 0, {8{~l1[7]}}, {8{~l0[7]}}));
    for (int i = 0; i < T_HS_EXIT; i++) sb_q.push_back(pack(0, 0, 1, 2'b11, 2'b11, 0, 0, 0, 8'h00, 8'h00));
    sb_q.push_back(pack(0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 8'h00, 8'h00));
  endtask

  task automatic fill_beats(input int n, input int drop);
    beats.delete();
    beat_vld.delete();
    for (int i = 0; i < n; i++) begin
      beats.push_back(16'($urandom));
      beat_vld.push_back(i != drop);
    end
  endtask

  task automatic run(input string name, input logic [7:0] di, input logic [15:0] wc, input int abort_at);
    logic [25:0] e;
    int          k, c;
    bit          got;
    sb_q.delete();
    build(di, wc);
    @(negedge sys_clk);
    bus.pkt_req = 1'b1;
    bus.pkt_di  = di;
    bus.pkt_wc  = wc;
    got = 0;
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge sys_clk);
      if (bus.pkt_ack) got = 1;
    end
    bus.pkt_req = 1'b0;
    if (!got) begin
      check({name, "_ack"}, 32'(bus.pkt_ack), 32'd1);
      return;
    end
    k = 0;
    c = 0;
    while (sb_q.size() > 0) begin
      if (c > 0) @(negedge sys_clk);
      e = sb_q.pop_front();
      check(name, 32'(obs()), 32'(e));
      if (e[17]) begin
        bus.pl_data  = beats[k];
        bus.pl_valid = beat_vld[k];
        k++;
      end else begin
        bus.pl_data  = 16'($urandom);
        bus.pl_valid = 1'b1;
      end
      if (c == abort_at) begin
        reset = 1'b1;
        sb_q.delete();
        @(negedge sys_clk);
        check({name, "_rst"}, 32'(obs()), 32'(pack(0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 8'h00, 8'h00)));
        reset = 1'b0;
      end
      c++;
    end
  endtask

  initial begin
    string       s;
    logic [15:0] crc;
    int          pl0;
    pl0 = T_LPX + T_HS_PREP + T_HS_ZERO + 3;
    bus.pkt_req  = 1'b0;
    bus.pkt_di   = 8'h00;
    bus.pkt_wc   = 16'h0000;
    bus.pl_data  = 16'h0000;
    bus.pl_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("reset_state", 32'(obs()), 32'(pack(0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 8'h00, 8'h00)));
    reset = 1'b0;

    s = "123456789";
    crc = 16'hFFFF;
    for (int i = 0; i < s.len(); i++) crc = crc_ref(crc, s[i]);
    check("crc_model", 32'(crc), 32'h6F91);
    check("ecc_model", 32'(ecc_ref(24'h000100)), 32'h1A);

    fill_beats(0, -1);
    run("frame_start", 8'h00, 16'h0001, -1);

    fill_beats(320, -1);
    run("long_full", 8'h2A, 16'h0280, -1);

    fill_beats(320, 10);
    run("long_underrun", 8'h2A, 16'h0280, -1);

    @(negedge sys_clk);
    bus.pkt_req = 1'b1;
    bus.pkt_di  = 8'h2A;
    bus.pkt_wc  = 16'h0003;
    @(negedge sys_clk);
    bus.pkt_req = 1'b0;
    check("odd_wc_reject", 32'(obs()), 32'(pack(0, 1, 0, 2'b11, 2'b11, 0, 0, 0, 8'h00, 8'h00)));
    @(negedge sys_clk);
    check("odd_wc_idle", 32'(obs()), 32'(pack(0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 8'h00, 8'h00)));

    fill_beats(320, -1);
    run("abort", 8'h2A, 16'h0280, pl0 + 5);

    fill_beats(4, -1);
    run("after_abort", 8'h2A, 16'h0008, -1);

    fill_beats(0, -1);
    run("wc_zero", 8'h2A, 16'h0000, -1);

    fill_beats(0, -1);
    run("short_vc1", 8'h41, 16'hA5F0, -1);

    fill_beats(3, 0);
    run("long_first_drop", 8'hD2, 16'h0006, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
